// File: rtl/fifo_arbiter.sv
// Round-robin scheduler moving words from four input FIFOs to four output FIFOs by destination field,
// with threshold programming for all eight FIFOs and a sticky overflow/underflow error state.
module fifo_arbiter #(
    parameter int DATA_W = 6,
    parameter int THR_W  = 5,
    parameter int AE_DEF = 1,
    parameter int AF_DEF = 6
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  init,
    input  logic [THR_W-1:0]      cfg_al_empty,
    input  logic [THR_W-1:0]      cfg_al_full,
    input  logic [3:0]            in_empty,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_rd,
    input  logic [3:0]            out_pause,
    output logic [3:0]            out_wr,
    output logic [DATA_W-1:0]     out_data,
    output logic [THR_W-1:0]      al_empty_thr,
    output logic [THR_W-1:0]      al_full_thr,
    input  logic [7:0]            fifo_err,
    output logic [2:0]            state,
    output logic                  idle,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_s;
    logic [1:0]          ptr_r;
    logic [3:0]          elig_s;
    logic                grant_s;
    logic [1:0]          gidx_s;
    logic [DATA_W-1:0]   gword_s;
    logic                xfer_s;
    logic                err_s;
    logic [3:0]          out_wr_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [THR_W-1:0]    ae_thr_r;
    logic [THR_W-1:0]    af_thr_r;
    logic                idle_r;
    logic                error_r;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    assign err_s = |fifo_err;

    // Eligibility: head present and its destination FIFO not almost-full
    always_comb begin
        elig_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            elig_s[i] = ~in_empty[i] & ~out_pause[in_data[DATA_W*i + DATA_W - 2 +: 2]];
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        logic [1:0] cand;
        logic       take;
        grant_s = 1'b0;
        gidx_s  = 2'd0;
        cand    = 2'd0;
        take    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand    = ptr_r + 2'(k);
            take    = ~grant_s & elig_s[cand];
            gidx_s  = take ? cand : gidx_s;
            grant_s = grant_s | take;
        end
    end

    // A pop is withheld when init or an error is pending so no word is lost on exit
    always_comb begin
        xfer_s  = (state_r == ST_ACTIVE) && !init && !err_s && grant_s;
        gword_s = in_data[DATA_W*gidx_s +: DATA_W];
        if (xfer_s) begin
            in_rd = onehot4(gidx_s);
        end else begin
            in_rd = 4'b0000;
        end
    end

    // Next-state selection; errors outrank init, init outranks traffic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_RESET: next_s = ST_INIT;
            ST_INIT: begin
                if (err_s)     next_s = ST_ERROR;
                else if (init) next_s = ST_INIT;
                else           next_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (err_s)                  next_s = ST_ERROR;
                else if (init)              next_s = ST_INIT;
                else if (in_empty != 4'hF)  next_s = ST_ACTIVE;
                else                        next_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (err_s)          next_s = ST_ERROR;
                else if (init)      next_s = ST_INIT;
                else if (&in_empty) next_s = ST_IDLE;
                else                next_s = ST_ACTIVE;
            end
            ST_ERROR: begin
                if (init) next_s = ST_INIT;
                else      next_s = ST_ERROR;
            end
            default: next_s = ST_ERROR;
        endcase
    end

    // State register with decoded status flags
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_RESET;
            idle_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= next_s;
            idle_r  <= (next_s == ST_IDLE);
            error_r <= (next_s == ST_ERROR);
        end
    end

    // Round-robin pointer; reset value 3 gives channel 0 first priority
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ptr_r <= 2'd3;
        end else if (xfer_s) begin
            ptr_r <= gidx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Registered push toward the output FIFO selected by the word's destination field
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            out_wr_r   <= 4'b0000;
            out_data_r <= '0;
        end else if (xfer_s) begin
            out_wr_r   <= onehot4(gword_s[DATA_W-1 -: 2]);
            out_data_r <= gword_s;
        end else begin
            out_wr_r   <= 4'b0000;
            out_data_r <= out_data_r;
        end
    end

    // Thresholds follow the config inputs only while in INIT
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ae_thr_r <= THR_W'(AE_DEF);
            af_thr_r <= THR_W'(AF_DEF);
        end else if (state_r == ST_INIT) begin
            ae_thr_r <= cfg_al_empty;
            af_thr_r <= cfg_al_full;
        end else begin
            ae_thr_r <= ae_thr_r;
            af_thr_r <= af_thr_r;
        end
    end

    assign state        = state_r;
    assign idle         = idle_r;
    assign error        = error_r;
    assign out_wr       = out_wr_r;
    assign out_data     = out_data_r;
    assign al_empty_thr = ae_thr_r;
    assign al_full_thr  = af_thr_r;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: a per-cycle vector table for round-robin and pause bypass,
// plus hand sequences for config, single word, error recovery and asynchronous reset.
module tb_fifo_arbiter;

    logic        clk;
    logic        RESET;
    logic        init;
    logic [4:0]  cfg_al_empty;
    logic [4:0]  cfg_al_full;
    logic [3:0]  in_empty;
    logic [23:0] in_data;
    logic [3:0]  in_rd;
    logic [3:0]  out_pause;
    logic [3:0]  out_wr;
    logic [5:0]  out_data;
    logic [4:0]  al_empty_thr;
    logic [4:0]  al_full_thr;
    logic [7:0]  fifo_err;
    logic [2:0]  state;
    logic        idle;
    logic        error;

    int total;
    int bad;

    fifo_arbiter dut (
        .clk          (clk),
        .RESET        (RESET),
        .init         (init),
        .cfg_al_empty (cfg_al_empty),
        .cfg_al_full  (cfg_al_full),
        .in_empty     (in_empty),
        .in_data      (in_data),
        .in_rd        (in_rd),
        .out_pause    (out_pause),
        .out_wr       (out_wr),
        .out_data     (out_data),
        .al_empty_thr (al_empty_thr),
        .al_full_thr  (al_full_thr),
        .fifo_err     (fifo_err),
        .state        (state),
        .idle         (idle),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  empty;
        logic [23:0] data;
        logic [3:0]  pause;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic [5:0]  odata;
        logic [2:0]  st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] e, input logic [23:0] d, input logic [3:0] p,
                       input logic [3:0] rd, input logic [3:0] wr, input logic [5:0] od,
                       input logic [2:0] st);
        vec_t v;
        v.empty = e; v.data = d; v.pause = p; v.rd = rd; v.wr = wr; v.odata = od; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESET = 1'b1; init = 1'b0; cfg_al_empty = 5'd0; cfg_al_full = 5'd0;
        in_empty = 4'hF; in_data = 24'h0; out_pause = 4'h0; fifo_err = 8'h00;

        // Round-robin: 3 words per channel, word = {dest, ch, n}, dest = (ch+n+1)%4
        add(4'h0, {6'h0C, 6'h38, 6'h24, 6'h10}, 4'h0, 4'h0, 4'h0, 6'h00, 3'd2);
        add(4'h0, {6'h0C, 6'h38, 6'h24, 6'h10}, 4'h0, 4'h1, 4'h0, 6'h00, 3'd3);
        add(4'h0, {6'h0C, 6'h38, 6'h24, 6'h21}, 4'h0, 4'h2, 4'h2, 6'h10, 3'd3);
        add(4'h0, {6'h0C, 6'h38, 6'h35, 6'h21}, 4'h0, 4'h4, 4'h4, 6'h24, 3'd3);
        add(4'h0, {6'h0C, 6'h09, 6'h35, 6'h21}, 4'h0, 4'h8, 4'h8, 6'h38, 3'd3);
        add(4'h0, {6'h1D, 6'h09, 6'h35, 6'h21}, 4'h0, 4'h1, 4'h1, 6'h0C, 3'd3);
        add(4'h0, {6'h1D, 6'h09, 6'h35, 6'h32}, 4'h0, 4'h2, 4'h4, 6'h21, 3'd3);
        add(4'h0, {6'h1D, 6'h09, 6'h06, 6'h32}, 4'h0, 4'h4, 4'h8, 6'h35, 3'd3);
        add(4'h0, {6'h1D, 6'h1A, 6'h06, 6'h32}, 4'h0, 4'h8, 4'h1, 6'h09, 3'd3);
        add(4'h0, {6'h2E, 6'h1A, 6'h06, 6'h32}, 4'h0, 4'h1, 4'h2, 6'h1D, 3'd3);
        add(4'h1, {6'h2E, 6'h1A, 6'h06, 6'h32}, 4'h0, 4'h2, 4'h8, 6'h32, 3'd3);
        add(4'h3, {6'h2E, 6'h1A, 6'h06, 6'h32}, 4'h0, 4'h4, 4'h1, 6'h06, 3'd3);
        add(4'h7, {6'h2E, 6'h1A, 6'h06, 6'h32}, 4'h0, 4'h8, 4'h2, 6'h1A, 3'd3);
        add(4'hF, {6'h2E, 6'h1A, 6'h06, 6'h32}, 4'h0, 4'h0, 4'h4, 6'h2E, 3'd3);
        add(4'hF, 24'h0,                        4'h0, 4'h0, 4'h0, 6'h2E, 3'd2);
        // Pause bypass: ch0 -> dest 1 (paused), ch1 -> dest 3
        add(4'hC, {6'h00, 6'h00, 6'h31, 6'h10}, 4'h2, 4'h0, 4'h0, 6'h2E, 3'd2);
        add(4'hC, {6'h00, 6'h00, 6'h31, 6'h10}, 4'h2, 4'h2, 4'h0, 6'h2E, 3'd3);
        add(4'hE, {6'h00, 6'h00, 6'h31, 6'h10}, 4'h2, 4'h0, 4'h8, 6'h31, 3'd3);
        add(4'hE, {6'h00, 6'h00, 6'h31, 6'h10}, 4'h2, 4'h0, 4'h0, 6'h31, 3'd3);
        add(4'hE, {6'h00, 6'h00, 6'h31, 6'h10}, 4'h0, 4'h1, 4'h0, 6'h31, 3'd3);
        add(4'hF, 24'h0,                        4'h0, 4'h0, 4'h2, 6'h10, 3'd3);
        add(4'hF, 24'h0,                        4'h0, 4'h0, 4'h0, 6'h10, 3'd2);

        // Reset values
        cyc(); #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_in_rd", 32'(in_rd), 32'd0);
        chk("rst_out_wr", 32'(out_wr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_ae", 32'(al_empty_thr), 32'd1);
        chk("rst_af", 32'(al_full_thr), 32'd6);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Configuration through INIT
        RESET = 1'b0; init = 1'b1; cfg_al_empty = 5'd2; cfg_al_full = 5'd6;
        cyc(); #1;
        chk("cfg_state_init", 32'(state), 32'd1);
        cyc(); init = 1'b0; #1;
        chk("cfg_ae_loaded", 32'(al_empty_thr), 32'd2);
        cyc(); #1;
        chk("cfg_state_idle", 32'(state), 32'd2);
        chk("cfg_idle", 32'(idle), 32'd1);
        chk("cfg_af", 32'(al_full_thr), 32'd6);
        cfg_al_empty = 5'd9; cfg_al_full = 5'd12;

        // Table: one row per clock cycle
        for (int r = 0; r < vecs.size(); r++) begin
            cyc();
            in_empty = vecs[r].empty; in_data = vecs[r].data; out_pause = vecs[r].pause;
            #1;
            chk($sformatf("vec%0d_in_rd", r), 32'(in_rd), 32'(vecs[r].rd));
            chk($sformatf("vec%0d_out_wr", r), 32'(out_wr), 32'(vecs[r].wr));
            chk($sformatf("vec%0d_out_data", r), 32'(out_data), 32'(vecs[r].odata));
            chk($sformatf("vec%0d_state", r), 32'(state), 32'(vecs[r].st));
            chk($sformatf("vec%0d_idle", r), 32'(idle), (vecs[r].st == 3'd2) ? 32'd1 : 32'd0);
        end
        chk("hold_ae", 32'(al_empty_thr), 32'd2);
        chk("hold_af", 32'(al_full_thr), 32'd6);

        // Single word: ch0 head 100100 (dest 2)
        cyc(); in_empty = 4'hE; in_data = 24'h000024; #1;
        chk("sw_idle_no_rd", 32'(in_rd), 32'd0);
        cyc(); #1;
        chk("sw_state_active", 32'(state), 32'd3);
        chk("sw_in_rd", 32'(in_rd), 32'h1);
        chk("sw_no_wr_yet", 32'(out_wr), 32'd0);
        cyc(); in_empty = 4'hF; #1;
        chk("sw_out_wr", 32'(out_wr), 32'h4);
        chk("sw_out_data", 32'(out_data), 32'h24);
        chk("sw_rd_done", 32'(in_rd), 32'd0);
        cyc(); #1;
        chk("sw_back_idle", 32'(state), 32'd2);
        chk("sw_wr_off", 32'(out_wr), 32'd0);

        // Error: ch0 dest 0, ch1 dest 2; ptr sits at 0 so ch1 goes first
        cyc(); in_empty = 4'hC; in_data = {6'h00, 6'h00, 6'h22, 6'h01}; #1;
        chk("err_pre_idle", 32'(state), 32'd2);
        cyc(); #1;
        chk("err_grant_ch1", 32'(in_rd), 32'h2);
        cyc(); in_empty = 4'hE; fifo_err = 8'h20; #1;
        chk("err_wr_completes", 32'(out_wr), 32'h4);
        chk("err_wr_data", 32'(out_data), 32'h22);
        cyc(); fifo_err = 8'h00; #1;
        chk("err_state", 32'(state), 32'd4);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_no_rd", 32'(in_rd), 32'd0);
        chk("err_no_wr", 32'(out_wr), 32'd0);
        cyc(); #1;
        chk("err_sticky", 32'(state), 32'd4);
        chk("err_sticky_rd", 32'(in_rd), 32'd0);
        chk("err_sticky_wr", 32'(out_wr), 32'd0);
        init = 1'b1; cfg_al_empty = 5'd3; cfg_al_full = 5'd7;
        cyc(); #1;
        chk("err_exit_init", 32'(state), 32'd1);
        chk("err_cleared", 32'(error), 32'd0);
        cyc(); init = 1'b0; #1;
        chk("reinit_ae", 32'(al_empty_thr), 32'd3);
        chk("reinit_af", 32'(al_full_thr), 32'd7);
        cyc(); in_empty = 4'hF; #1;
        chk("reinit_idle", 32'(state), 32'd2);

        // Asynchronous reset while a push is on out_wr; ptr sits at 1 so ch2 goes next
        cyc(); in_empty = 4'hB; in_data = {6'h00, 6'h3A, 6'h00, 6'h00}; #1;
        chk("ar_pre_idle", 32'(state), 32'd2);
        cyc(); #1;
        chk("ar_grant_ch2", 32'(in_rd), 32'h4);
        cyc(); in_empty = 4'hF; #1;
        chk("ar_wr_high", 32'(out_wr), 32'h8);
        #2; RESET = 1'b1; #1;
        chk("ar_wr_dropped", 32'(out_wr), 32'd0);
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        chk("ar_in_rd", 32'(in_rd), 32'd0);
        chk("ar_ae", 32'(al_empty_thr), 32'd1);
        chk("ar_af", 32'(al_full_thr), 32'd6);
        cyc(); RESET = 1'b0;
        cyc(); #1;
        chk("ar_to_init", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
